// File: rtl/c_accum_window_pkg.sv
// Shared helpers for the windowed accumulator: ceiling-log2 sizing function.
package c_accum_window_pkg;

    // Bits needed to represent values 0..value-1; clogb(1) == 0.
    function automatic int clogb(input int value);
        int r;
        r = 0;
        while ((1 << r) < value)
            r = r + 1;
        return r;
    endfunction

endpackage

// File: rtl/c_accum_window.sv
// Sums a window of unsigned samples (or a flushed partial window) into a
// one-entry registered output with ready/valid flow control on both sides.
module c_accum_window
    import c_accum_window_pkg::*;
#(
    parameter int in_width = 10,
    parameter int window   = 4
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic                                  in_valid,
    input  logic [0:in_width-1]                   in_data,
    input  logic                                  flush,
    output logic                                  in_ready,
    output logic                                  out_valid,
    output logic [0:in_width+clogb(window)-1]     out_data,
    output logic [0:clogb(window+1)-1]            out_count,
    input  logic                                  out_ready
);

    localparam int cnt_width = clogb(window + 1);
    localparam int acc_width = in_width + clogb(window);

    logic [0:acc_width-1] acc;
    logic [0:cnt_width-1] count;

    logic                 last;
    logic                 would_emit;
    logic                 accept;
    logic                 take;
    logic                 emit;
    logic [0:acc_width-1] in_ext;
    logic [0:acc_width-1] sum;

    assign last       = (count == cnt_width'(window - 1));
    assign would_emit = (last & in_valid) | flush;
    // Only stall when a new result must load while the held one is still unconsumed.
    assign in_ready   = ~(out_valid & ~out_ready & would_emit);
    assign accept     = in_valid & in_ready;
    assign take       = flush & in_ready;
    assign emit       = (accept & last) | (take & ((count != '0) | accept));
    assign in_ext     = acc_width'(in_data);
    assign sum        = acc + (accept ? in_ext : '0);

    always_ff @(posedge clk) begin
        if (!reset) begin
            acc       <= '0;
            count     <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_count <= '0;
        end else begin
            if (emit) begin
                out_data  <= sum;
                out_count <= count + cnt_width'(accept);
                out_valid <= 1'b1;
                acc       <= '0;
                count     <= '0;
            end else begin
                if (accept) begin
                    acc   <= sum;
                    count <= count + cnt_width'(1);
                end
                if (out_ready)
                    out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_c_accum_window.sv
// Randomized and directed check of c_accum_window against a queue-based window model.
module tb_c_accum_window;
    localparam int W  = 4;
    localparam int IW = 10;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic [0:IW-1] in_data;
    logic          flush;
    logic          in_ready;
    logic          out_valid;
    logic [0:11]   out_data;
    logic [0:2]    out_count;
    logic          out_ready;

    c_accum_window #(.in_width(IW), .window(W)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
        .flush(flush), .in_ready(in_ready), .out_valid(out_valid),
        .out_data(out_data), .out_count(out_count), .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference: samples of the open window, plus the held result.
    int win[$];
    bit m_pend;
    int m_psum;
    int m_pcnt;

    task automatic chk(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int win_sum();
        int s = 0;
        foreach (win[i]) s += win[i];
        return s;
    endfunction

    task automatic model_clear();
        win.delete();
        m_pend = 0;
        m_psum = 0;
        m_pcnt = 0;
    endtask

    // Drive one cycle, check outputs at negedge, advance the model across the edge.
    task automatic step(input bit v, input int d, input bit f, input bit ordy, input bit rst_n);
        bit m_rdy, acc_b, tk, em;
        reset = rst_n; in_valid = v; in_data = IW'(d); flush = f; out_ready = ordy;
        @(negedge clk);
        m_rdy = !(m_pend && !ordy && ((v && win.size() == W - 1) || f));
        chk("in_ready", int'(in_ready), int'(m_rdy));
        chk("out_valid", int'(out_valid), int'(m_pend));
        if (m_pend) begin
            chk("out_data", int'(out_data), m_psum);
            chk("out_count", int'(out_count), m_pcnt);
        end
        if (!rst_n) model_clear();
        else begin
            acc_b = v && m_rdy;
            tk    = f && m_rdy;
            if (acc_b) win.push_back(d);
            em = (win.size() == W) || (tk && win.size() > 0);
            if (em) begin
                m_pend = 1;
                m_psum = win_sum();
                m_pcnt = win.size();
                win.delete();
            end else if (ordy) m_pend = 0;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 0; in_valid = 0; in_data = '0; flush = 0; out_ready = 0;
        repeat (2) @(posedge clk);
        #1;
        model_clear();
        step(0, 0, 0, 1, 0);
        chk("rst_out_data", int'(out_data), 0);
        chk("rst_in_ready", int'(in_ready), 1);

        step(0, 0, 0, 1, 1);
        chk("idle_out_valid", int'(out_valid), 0);

        // 1,2,3,4 -> 10
        for (int i = 1; i <= 4; i++) step(1, i, 0, 1, 1);
        chk("r1_valid", int'(out_valid), 1);
        chk("r1_data", int'(out_data), 10);
        chk("r1_count", int'(out_count), 4);

        // stall with result pending
        for (int i = 5; i <= 7; i++) step(1, i, 0, 0, 1);
        step(1, 8, 0, 0, 1);
        chk("stall_hold_data", int'(out_data), 10);
        step(1, 8, 0, 1, 1);
        chk("r2_data", int'(out_data), 26);
        chk("r2_count", int'(out_count), 4);
        step(0, 0, 0, 1, 1);

        // max samples, no wrap
        for (int i = 0; i < 4; i++) step(1, 1023, 0, 1, 1);
        chk("max_data", int'(out_data), 4092);
        chk("max_count", int'(out_count), 4);
        step(0, 0, 0, 1, 1);

        // partial flush, then empty flush
        step(1, 7, 0, 1, 1);
        step(1, 9, 0, 1, 1);
        step(0, 0, 1, 1, 1);
        chk("flush_data", int'(out_data), 16);
        chk("flush_count", int'(out_count), 2);
        step(0, 0, 1, 1, 1);
        chk("empty_flush_valid", int'(out_valid), 0);

        // reset mid-window
        step(1, 3, 0, 1, 1);
        step(1, 3, 0, 1, 1);
        step(0, 0, 0, 1, 0);
        for (int i = 0; i < 4; i++) step(1, 1, 0, 1, 1);
        chk("post_rst_data", int'(out_data), 4);
        chk("post_rst_count", int'(out_count), 4);

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            int d;
            d = ($urandom_range(0, 7) == 0) ? 1023 : int'($urandom_range(0, 1023));
            step($urandom_range(0, 3) != 0, d, $urandom_range(0, 7) == 0,
                 $urandom_range(0, 1) == 1, $urandom_range(0, 99) != 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
